// File: rtl/multiplier_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier. It watches level-held operands,
// recomputes whenever they change, and holds the last completed product.
module multiplier_8bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_op_a;
  logic [7:0]  r_op_b;
  logic        r_valid;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [3:0]  r_cnt;
  logic [15:0] r_result;
  logic        r_done;
  logic        w_changed;
  logic        w_load;
  logic        w_step;

  assign w_changed = (a != r_op_a) || (b != r_op_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // An operand change in RUN reloads the datapath and restarts the 8 steps.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_valid || w_changed) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_changed) begin
          w_load = 1'b1;
        end else begin
          w_step = 1'b1;
          if (r_cnt == 4'd7) w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_valid  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) r_result <= r_acc;
      if (w_load) begin
        r_op_a   <= a;
        r_op_b   <= b;
        r_valid  <= 1'b1;
        r_acc    <= '0;
        r_mcand  <= {8'b0, a};
        r_mplier <= b;
        r_cnt    <= '0;
      end else if (w_step) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 4'd1;
      end
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_multiplier_8bit.sv
// Directed bench for multiplier_8bit: latency, products, abort/restart and async reset.
module tb_multiplier_8bit;

  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] result;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  multiplier_8bit dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts edges until done is seen (bounded); flags any result change before done.
  task automatic wait_done(output int n, output bit early);
    logic [15:0] prev;
    prev  = result;
    early = 1'b0;
    n     = 0;
    while (n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
      if (result !== prev) early = 1'b1;
    end
  endtask

  // Holds operands for a number of cycles, counting done pulses and busy cycles.
  task automatic idle_watch(input int cycles, output int n_done, output int n_busy);
    n_done = 0;
    n_busy = 0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
  endtask

  task automatic run_vec(input logic [7:0] va, input logic [7:0] vb,
                         input logic [15:0] exp, input string tag);
    int  n;
    bit  early;
    a = va;
    b = vb;
    wait_done(n, early);
    check({tag, "_latency"}, n, 10);
    check({tag, "_result"}, result, exp);
    check({tag, "_held"}, early, 0);
  endtask

  initial begin
    int  n;
    bit  early;
    int  nd;
    int  nb;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    a = 8'd5;
    b = 8'd10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    rst = 1'b0;
    wait_done(n, early);
    check("first_latency", n, 10);
    check("first_result", result, 50);
    check("first_done", done, 1);
    @(posedge clk);
    @(negedge clk);
    check("first_done_drop", done, 0);
    check("first_busy_drop", busy, 0);
    idle_watch(20, nd, nb);
    check("first_idle_done", nd, 0);
    check("first_idle_busy", nb, 0);

    run_vec(8'd3,   8'd8,   16'd24,    "v3x8");
    run_vec(8'd15,  8'd7,   16'd105,   "v15x7");
    run_vec(8'd0,   8'd255, 16'd0,     "v0x255");
    run_vec(8'd100, 8'd0,   16'd0,     "v100x0");
    run_vec(8'd255, 8'd255, 16'd65025, "v255x255");
    run_vec(8'd1,   8'd255, 16'd255,   "v1x255");
    run_vec(8'd128, 8'd2,   16'd256,   "v128x2");

    // Abort: start 5x10, change b to 3 after four edges.
    a = 8'd5;
    b = 8'd10;
    nd = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_busy", busy, 1);
    b = 8'd3;
    wait_done(n, early);
    check("abort_no_done", nd, 0);
    check("abort_latency", n, 10);
    check("abort_result", result, 15);
    check("abort_held", early, 0);

    // Async reset mid-computation, then recompute held operands.
    a = 8'd12;
    b = 8'd12;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_result", result, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_done(n, early);
    check("arst_latency", n, 10);
    check("arst_result2", result, 144);

    idle_watch(25, nd, nb);
    check("final_idle_done", nd, 0);
    check("final_idle_busy", nb, 0);
    check("final_result", result, 144);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
